// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: alternating instruction/data arbiter for one shared fixed-latency memory port
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 2,
  parameter bit D_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_ready,
  output logic [15:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ready,
  output logic [15:0] d_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_readM,
  output logic        mem_writeM,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic [15:0] i_wait_cycles
);
  typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;
  localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);
  state_t state;
  logic [3:0] cnt;
  logic [15:0] addr_q, wdata_q;
  logic we_q, done, grant_i, grant_d;
  assign busy = state != IDLE;
  assign i_ready = state == I_ACC && cnt == LAST;
  assign d_ready = state == D_ACC && cnt == LAST;
  assign done = i_ready || d_ready;
  assign i_rdata = i_ready ? mem_rdata : '0;
  assign d_rdata = d_ready && !we_q ? mem_rdata : '0;
  assign mem_addr = busy ? addr_q : '0;
  assign mem_readM = state == I_ACC || (state == D_ACC && !we_q);
  assign mem_writeM = state == D_ACC && we_q;
  assign mem_wdata = mem_writeM ? wdata_q : '0;
  // the side completing this cycle can never win the next grant
  always_comb begin
    grant_d = busy ? state == I_ACC && i_ready && d_req : d_req && (D_FIRST || !i_req);
    grant_i = busy ? state == D_ACC && d_ready && i_req : i_req && !(D_FIRST && d_req);
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      i_wait_cycles <= '0;
    end else begin
      if (grant_d) begin
        state <= D_ACC;
        cnt <= '0;
        addr_q <= d_addr;
        wdata_q <= d_wdata;
        we_q <= d_we;
      end else if (grant_i) begin
        state <= I_ACC;
        cnt <= '0;
        addr_q <= i_addr;
        we_q <= 1'b0;
      end else if (done) begin
        state <= IDLE;
        cnt <= '0;
      end else if (busy) cnt <= cnt + 4'd1;
      if (i_req && !i_ready && i_wait_cycles != 16'hFFFF) i_wait_cycles <= i_wait_cycles + 16'd1;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with directed scenarios, randomized traffic and a saturation run
module tb_mem_port_arbiter;
  localparam int L = 2;
  typedef struct {logic [15:0] addr; logic [15:0] rdata; logic [15:0] wdata; logic we;} txn_t;
  logic clk = 1'b0, reset_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic i_ready, d_ready, mem_readM, mem_writeM, busy;
  logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata, i_wait_cycles;
  logic s_reset_n = 1'b0, s_i_req = 1'b0, s_d_req = 1'b0;
  logic s_i_ready, s_d_ready, s_readM, s_writeM, s_busy;
  logic [15:0] s_i_rdata, s_d_rdata, s_addr, s_wdata, s_iw;
  logic [15:0] ram [256];
  logic [15:0] ref_mem [256];
  txn_t iq[$], dq[$];
  bit order[$];
  bit mon_on = 1'b0, alt_on = 1'b0;
  int checks = 0, failures = 0, cyc = 0, i_start = 0, d_start = 0;
  logic [15:0] wmod = '0;

  mem_port_arbiter #(.MEM_LATENCY(L), .D_FIRST(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_readM(mem_readM), .mem_writeM(mem_writeM),
    .mem_rdata(mem_rdata), .busy(busy), .i_wait_cycles(i_wait_cycles));

  mem_port_arbiter #(.MEM_LATENCY(15), .D_FIRST(1'b1)) u_sat (
    .clk(clk), .reset_n(s_reset_n), .i_req(s_i_req), .i_addr(16'h0001), .i_ready(s_i_ready), .i_rdata(s_i_rdata),
    .d_req(s_d_req), .d_we(1'b0), .d_addr(16'h0002), .d_wdata(16'h0000), .d_ready(s_d_ready), .d_rdata(s_d_rdata),
    .mem_addr(s_addr), .mem_wdata(s_wdata), .mem_readM(s_readM), .mem_writeM(s_writeM),
    .mem_rdata(16'h0000), .busy(s_busy), .i_wait_cycles(s_iw));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_writeM && d_ready) ram[mem_addr[7:0]] <= mem_wdata;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every ready pulse and tracks the wait counter by its rule
  always @(negedge clk) if (mon_on) begin
    int lat;
    txn_t e;
    chk("i_wait_cycles", i_wait_cycles, wmod);
    wmod = !reset_n ? 16'h0 : (i_req && !i_ready && wmod != 16'hFFFF) ? wmod + 16'd1 : wmod;
    if (!busy) chk("idle_mem_zero", {mem_readM, mem_writeM, mem_addr, mem_wdata}, 0);
    if (i_ready) begin
      if (iq.size() == 0) chk("i_ready_spurious", i_ready, 0);
      else begin
        e = iq.pop_front();
        lat = cyc - i_start;
        chk("i_rdata", i_rdata, e.rdata);
        chk("i_mem_addr", {mem_addr, mem_readM, mem_writeM}, {e.addr, 2'b10});
        chk("i_latency_bound", lat >= L && lat <= 2 * L, 1);
        if (alt_on) order.push_back(1'b0);
      end
    end else chk("i_rdata_zero", i_rdata, 0);
    if (d_ready) begin
      if (dq.size() == 0) chk("d_ready_spurious", d_ready, 0);
      else begin
        e = dq.pop_front();
        lat = cyc - d_start;
        chk("d_rdata", d_rdata, e.rdata);
        chk("d_mem_addr", {mem_addr, mem_writeM, mem_readM}, {e.addr, e.we, !e.we});
        if (e.we) chk("d_mem_wdata", mem_wdata, e.wdata);
        chk("d_latency_bound", lat >= L && lat <= 2 * L, 1);
        if (alt_on) order.push_back(1'b1);
      end
    end else chk("d_rdata_zero", d_rdata, 0);
  end

  task automatic issue_i(input logic [15:0] a);
    iq.push_back('{addr: a, rdata: ref_mem[a[7:0]], wdata: 16'h0, we: 1'b0});
    i_addr = a;
    i_req = 1'b1;
    i_start = cyc;
  endtask

  task automatic issue_d(input logic we, input logic [15:0] a, input logic [15:0] w);
    if (we) begin
      dq.push_back('{addr: a, rdata: 16'h0, wdata: w, we: 1'b1});
      ref_mem[a[7:0]] = w;
    end else dq.push_back('{addr: a, rdata: ref_mem[a[7:0]], wdata: 16'h0, we: 1'b0});
    d_we = we;
    d_addr = a;
    d_wdata = w;
    d_req = 1'b1;
    d_start = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  // instruction addresses keep bit 7 clear, data addresses set it, so fetches never see data writes
  task automatic i_drive(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      int t;
      @(posedge clk); #1 i_req = 1'b0;
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      issue_i({8'($urandom), 1'b0, 7'($urandom)});
      t = 0;
      @(negedge clk);
      while (!i_ready && t < 20) begin t++; @(negedge clk); end
      chk("i_timeout", i_ready, 1);
    end
    @(posedge clk); #1 i_req = 1'b0;
  endtask

  task automatic d_drive(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      int t;
      @(posedge clk); #1 d_req = 1'b0;
      repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
      issue_d(1'($urandom), {8'($urandom), 1'b1, 7'($urandom)}, 16'($urandom));
      t = 0;
      @(negedge clk);
      while (!d_ready && t < 20) begin t++; @(negedge clk); end
      chk("d_timeout", d_ready, 1);
    end
    @(posedge clk); #1 d_req = 1'b0;
  endtask

  task automatic main_run();
    i_req = 1'b1;
    i_addr = 16'h0033;
    @(posedge clk); #1 mon_on = 1'b1;
    repeat (3) begin @(negedge clk); chk("reset_no_grant", {busy, i_wait_cycles}, 0); end
    @(posedge clk); #1 reset_n = 1'b1; i_req = 1'b0;
    @(negedge clk);
    chk("reset_outputs", {i_ready, i_rdata, d_ready, d_rdata, mem_addr, mem_wdata, mem_readM, mem_writeM, busy, i_wait_cycles}, 0);
    @(posedge clk); #1 issue_i(16'h0010);
    @(negedge clk); chk("fetch_c0_idle", busy, 0);
    @(negedge clk); chk("fetch_c1", {mem_readM, mem_writeM, mem_addr, i_ready}, {1'b1, 1'b0, 16'h0010, 1'b0});
    @(negedge clk); chk("fetch_c2", {mem_readM, mem_addr, i_ready, i_rdata}, {1'b1, 16'h0010, 1'b1, 16'hA5A5});
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk); chk("fetch_c3_idle", busy, 0);
    do_reset();
    issue_d(1'b0, 16'h0040, 16'h0);
    issue_i(16'h0011);
    @(negedge clk); chk("sim_c0_wait", i_wait_cycles, 0);
    @(negedge clk); chk("sim_c1_d", {busy, mem_readM, mem_addr}, {1'b1, 1'b1, 16'h0040});
    @(negedge clk); chk("sim_c2_dready", {d_ready, i_ready}, 2'b10);
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk); chk("sim_c3_i_no_gap", {busy, mem_readM, mem_addr}, {1'b1, 1'b1, 16'h0011});
    @(negedge clk); chk("sim_c4_iready", {i_ready, d_ready}, 2'b10);
    @(posedge clk); #1 i_req = 1'b0;
    @(negedge clk); chk("sim_wait4", {busy, i_wait_cycles}, {1'b0, 16'd4});
    @(posedge clk); #1 issue_d(1'b1, 16'h0020, 16'h1234);
    @(negedge clk);
    @(negedge clk); chk("wr_c1", {mem_writeM, mem_readM, mem_wdata, mem_addr, d_ready}, {2'b10, 16'h1234, 16'h0020, 1'b0});
    @(negedge clk); chk("wr_c2", {mem_writeM, mem_readM, mem_wdata, d_ready, d_rdata}, {2'b10, 16'h1234, 1'b1, 16'h0});
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk); chk("wr_c3", {busy, d_ready}, 0);
    @(posedge clk); #1 issue_i(16'h0005);
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0090;
    @(posedge clk); #1 d_req = 1'b0;
    @(negedge clk); chk("drop_iready", i_ready, 1);
    @(posedge clk); #1 i_req = 1'b0;
    repeat (4) begin @(negedge clk); chk("drop_no_access", {busy, d_ready}, 0); end
    @(posedge clk); #1 d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0085;
    @(posedge clk); #1 reset_n = 1'b0; d_req = 1'b0;
    @(negedge clk); chk("rstmid_in_access", {busy, mem_readM}, 2'b11);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rstmid_outputs", {busy, mem_readM, mem_writeM, d_ready, i_wait_cycles}, 0);
    repeat (4) begin @(negedge clk); chk("rstmid_no_dready", d_ready, 0); end
    do_reset();
    alt_on = 1'b1;
    fork i_drive(6, 0); d_drive(6, 0); join
    alt_on = 1'b0;
    chk("alt_count", order.size(), 12);
    for (int k = 1; k < order.size(); k++) chk("alternation", order[k] == order[k-1], 0);
    fork i_drive(150, 3); d_drive(150, 3); join
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", {32'(iq.size()), 32'(dq.size())}, 0);
  endtask

  task automatic sat_run();
    int t = 0;
    @(posedge clk); #1 s_reset_n = 1'b1; s_i_req = 1'b1; s_d_req = 1'b1;
    while (s_iw != 16'hFFFF && t < 80000) begin @(negedge clk); t++; end
    chk("sat_reached", s_iw, 16'hFFFF);
    repeat (200) @(negedge clk);
    chk("sat_no_wrap", s_iw, 16'hFFFF);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      ram[k] = 16'($urandom);
      ref_mem[k] = ram[k];
    end
    ram[16] = 16'hA5A5;
    ref_mem[16] = 16'hA5A5;
    fork main_run(); sat_run(); join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
